// File: rtl/fetch.sv
// fetch: front-end stage of the tensor-core pipeline.
// Owns the program counter and issues instruction-memory reads. Returned words
// are buffered with their PCs in an in-order circular queue, and the head of
// that queue is presented to dispatch. flush redirects the PC and empties the
// queue. freeze holds the head in place.
// Optional feature macro: FETCH_PERF_EN adds the perf_fetched / perf_stall counters.
module fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        flush,
    input  logic [31:0] branch_target,
    input  logic        freeze,
    input  logic        dispatch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_imemload,
    output logic [31:0] fetch_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Queue storage: PC and instruction word per entry. This storage is never reset.
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic full;
    logic push;
    logic pop;

    // Holding nRST in the request term keeps imem_ren low for as long as reset
    // is asserted. This holds even before the first clock edge.
    assign full        = (count_q == FULL_CNT);
    assign imem_ren    = nRST & ~flush & ~full;
    assign imem_addr   = pc_q;
    assign push        = imem_ren & ihit;
    assign fetch_valid = (count_q != '0);
    assign pop         = fetch_valid & dispatch_ready & ~freeze & ~flush;

    // The head is read from registered storage, so imemload has no
    // combinational path to the fetch_* outputs.
    assign fetch_pc       = pc_mem[rd_ptr_q];
    assign fetch_imemload = instr_mem[rd_ptr_q];

    // Next-state logic for the PC, the pointers and the count. flush overrides everything.
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            pc_d     = branch_target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                pc_d     = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register. It has an asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // On each push, write the returned word and its PC into the tail slot.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= pc_q;
            instr_mem[wr_ptr_q] <= imemload;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Free-running event counters. flush does not clear them; only reset does.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (imem_ren && !ihit) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch.sv
// Testbench for fetch.
// The reference model is a queue of {pc, instr} plus a model PC.
// A driver issues per-cycle stimulus and checks the request-side outputs.
// A separate monitor pops the expected head whenever the DUT consumes one and compares it.
module tb_fetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic [31:0] branch_target;
    logic        freeze;
    logic        dispatch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_imemload;
    logic [31:0] fetch_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .imem_ren       (imem_ren),
        .imem_addr      (imem_addr),
        .ihit           (ihit),
        .imemload       (imemload),
        .flush          (flush),
        .branch_target  (branch_target),
        .freeze         (freeze),
        .dispatch_ready (dispatch_ready),
        .fetch_valid    (fetch_valid),
        .fetch_imemload (fetch_imemload),
        .fetch_pc       (fetch_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [63:0] exp_q[$];   // {pc, instr} in program order
    logic [31:0] pc_m;
    logic [31:0] fetched_m;
    logic [31:0] stall_m;

    int vectors;
    int miscompares;
    logic [63:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_perf();
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, fetched_m);
        chk("perf_stall", perf_stall, stall_m);
`endif
    endtask

    // One clock of stimulus. Inputs are driven at the negedge and the
    // request side is checked 1 ns later. The model commits at the posedge.
    task automatic cycle(input bit ih, input bit rdy, input bit frz, input bit fl,
                         input logic [31:0] bt);
        bit          ren_m;
        bit          push_m;
        logic [31:0] word;
        @(negedge CLK);
        ihit           = ih;
        dispatch_ready = rdy;
        freeze         = frz;
        flush          = fl;
        branch_target  = bt;
        imemload       = $urandom;
        word           = imemload;
        #1;
        ren_m = !fl && (exp_q.size() < DEPTH);
        chk("imem_ren", {31'd0, imem_ren}, {31'd0, ren_m});
        chk("imem_addr", imem_addr, pc_m);
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, exp_q.size() != 0});
        chk_perf();
        push_m = ren_m && ih;
        @(posedge CLK);
        if (push_m) fetched_m++;
        if (ren_m && !ih) stall_m++;
        if (fl) begin
            exp_q.delete();
            pc_m = bt;
        end else if (push_m) begin
            exp_q.push_back({pc_m, word});
            pc_m = pc_m + 32'd4;
        end
    endtask

    // Assert reset mid-cycle while a request is outstanding. Check that the
    // outputs go to their reset values before any clock edge, then release.
    task automatic mid_reset();
        @(negedge CLK);
        ihit = 1'b0; dispatch_ready = 1'b0; freeze = 1'b0; flush = 1'b0;
        #3;
        nRST = 1'b0;
        #1;
        exp_q.delete();
        pc_m = RESET_PC; fetched_m = '0; stall_m = '0;
        chk("rst_imem_ren", {31'd0, imem_ren}, 32'd0);
        chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk_perf();
        @(posedge CLK);
        @(posedge CLK);
        #2;
        nRST = 1'b1;
    endtask

    // Monitor: whenever the DUT consumes its head, pop the expected entry and compare it.
    always @(negedge CLK) begin
        #2;
        if (nRST && fetch_valid && dispatch_ready && !freeze && !flush) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_empty: DUT consumed head pc=%h, expected empty queue", fetch_pc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("pop pc=%h instr=%h", fetch_pc, fetch_imemload);
                chk("head_pc", fetch_pc, mon_e[63:32]);
                chk("head_instr", fetch_imemload, mon_e[31:0]);
            end
        end
    end

    initial begin
        vectors = 0; miscompares = 0;
        pc_m = RESET_PC; fetched_m = '0; stall_m = '0;
        nRST = 1'b0; ihit = 1'b0; imemload = '0; flush = 1'b0;
        branch_target = '0; freeze = 1'b0; dispatch_ready = 1'b0;
        #1;
        chk("rst_imem_ren", {31'd0, imem_ren}, 32'd0);
        chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk_perf();
        @(posedge CLK);
        @(posedge CLK);
        #2;
        nRST = 1'b1;

        // Streaming: ihit and dispatch_ready held high
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, '0);

        // Fill to full with dispatch stalled, then release one pop
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, '0);
        cycle(1, 1, 0, 0, '0);
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0, '0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, '0);

        // Flush with 3 queued entries and a simultaneous ihit
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, '0);
        cycle(1, 0, 0, 1, 32'h0000_0200);
        cycle(0, 1, 0, 0, '0);

        // Freeze holds the head while the queue fills
        for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, '0);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, '0);

        // Memory withholds ihit for 3 cycles at 0x40
        cycle(0, 1, 0, 1, 32'h0000_0040);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, '0);
        cycle(1, 1, 0, 0, '0);
        cycle(0, 1, 0, 0, '0);

        // Asynchronous reset with two entries held and a request pending
        cycle(1, 0, 0, 1, 32'h0000_0080);
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0, '0);
        mid_reset();
        cycle(0, 1, 0, 0, '0);

        // The PC wraps through 2^32
        cycle(0, 1, 0, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, '0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] bt;
            bt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_FFFC);
            cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4, bt);
        end

        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
